cpu_apb_bridge: RTL and testbench
=================================

CPU_APB_BRIDGE -- requirements
Module: cpu_apb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the number of ACCESS cycles without pready before the bridge aborts the transfer.
REQ-002 SHALL have parameter PPROT_VAL, default 3'b000, meaning the constant driven on out_pprot.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset: 0 = reset asserted.
REQ-005 SHALL have ports in_req_valid (input, 1) and in_req_ready (output, 1): the upstream request handshake.
REQ-006 SHALL have ports in_req_addr (input, 32), in_req_write (input, 1), in_req_wdata (input, 32) and in_req_wstrb (input, 4): the request payload.
REQ-007 SHALL have ports in_resp_valid (output, 1) and in_resp_ready (input, 1): the response handshake.
REQ-008 SHALL have ports in_resp_rdata (output, 32) and in_resp_err (output, 1): the response payload.
REQ-009 SHALL have APB master outputs out_paddr (32), out_psel (1), out_penable (1), out_pprot (3), out_pwrite (1), out_pwdata (32) and out_pstrb (4).
REQ-010 SHALL have APB master inputs out_pready (1), out_prdata (32) and out_pslverr (1); these connect directly to an APB delayer or slave.

Function
REQ-011 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-012 IDLE: SHALL drive in_req_ready=1; on in_req_valid&&in_req_ready it SHALL latch addr/write/wdata/wstrb and go to SETUP.
REQ-013 SETUP (exactly 1 cycle): SHALL drive psel=1, penable=0 and the latched payload, then go to ACCESS.
REQ-014 ACCESS: SHALL drive psel=1, penable=1 with the payload held stable; when pready=1 it SHALL capture prdata into rdata (reads only) and pslverr into err, then go to RESP.
REQ-015 RESP: SHALL drive in_resp_valid=1 with rdata/err held stable until in_resp_ready=1, then go to IDLE.
REQ-016 in_req_ready SHALL be 0 in every state other than IDLE; no request buffering; at most one outstanding transfer.
REQ-017 For writes, in_resp_rdata SHALL read 0.
REQ-018 out_pwdata and out_pstrb SHALL be driven 0 on reads.
REQ-019 When psel=0, out_paddr, out_pwrite, out_pwdata and out_pstrb SHALL hold their last values; out_pprot SHALL always equal PPROT_VAL.
REQ-020 Minimum latency SHALL be 3 cycles from request accept to in_resp_valid (pready=1 on the first ACCESS cycle), plus 1 cycle per pready=0 cycle in ACCESS.
REQ-021 The earliest next accept SHALL be the cycle after the response handshake; there SHALL be no IDLE bypass.

Reset
REQ-022 While reset=0, the FSM SHALL be in IDLE, psel=penable=0, in_resp_valid=0, rdata=0, err=0, and all latched payload=0; in_req_ready SHALL be 1 after release.
REQ-023 Reset asserted mid-ACCESS SHALL drop psel/penable asynchronously; the in-flight transfer is discarded and no response is issued.

Configuration
REQ-024 With APB_TIMEOUT_EN defined: a 32-bit counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; reaching TIMEOUT_CYCLES SHALL force RESP with err=1 and rdata=32'hDEAD_BEEF, and psel SHALL drop.
REQ-025 With APB_TIMEOUT_EN undefined: there SHALL be no counter and ACCESS SHALL wait indefinitely for pready.

Structure
REQ-026 Package cpu_apb_pkg SHALL hold the FSM state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3), the timeout rdata constant, and the default PPROT.
REQ-027 The timeout counter SHALL be sub-module apb_timeout_cnt (enable, clear, expired) and is instantiated only under APB_TIMEOUT_EN.

Verification
REQ-028 Read addr 0x1000_0004, slave pready on 1st ACCESS with prdata 0x1234_5678 -> in_resp_valid 3 cycles after accept, rdata 0x1234_5678, err 0.
REQ-029 Write addr 0x1000_0008, wdata 0xA5A5_A5A5, wstrb 4'b0011, pready after 4 wait cycles -> payload stable across all 5 ACCESS cycles, response err 0, rdata 0.
REQ-030 Slave returns pslverr=1 on a read -> in_resp_err=1; in_resp_ready held 0 for 3 cycles -> resp stays valid and stable, in_req_ready=0 throughout.
REQ-031 Back-to-back requests with in_req_valid held high -> second accept exactly 1 cycle after the first response handshake.
REQ-032 Reset pulled low during ACCESS -> psel=0 immediately; after release in_req_ready=1 with no spurious in_resp_valid.
REQ-033 APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready stuck 0 -> RESP after 8 ACCESS cycles, err=1, rdata 0xDEAD_BEEF.

Source files
------------

// File: rtl/cpu_apb_pkg.sv
// cpu_apb_pkg: shared FSM encoding and constants for the CPU-to-APB bridge.
package cpu_apb_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam logic [2:0] PPROT_DEFAULT = 3'b000;
endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts stalled ACCESS cycles and flags the one that reaches LIMIT.
module apb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + 32'd1 : cnt_q;
  // Fires during the LIMIT-th stalled cycle so RESP follows exactly LIMIT ACCESS cycles.
  assign expired = enable && cnt_q == 32'(LIMIT - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cpu_apb_bridge.sv
// cpu_apb_bridge: single-outstanding valid/ready to APB master bridge.
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module cpu_apb_bridge
  import cpu_apb_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 256,
  parameter logic [2:0] PPROT_VAL      = PPROT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_req_valid,
  output logic        in_req_ready,
  input  logic [31:0] in_req_addr,
  input  logic        in_req_write,
  input  logic [31:0] in_req_wdata,
  input  logic [3:0]  in_req_wstrb,
  output logic        in_resp_valid,
  input  logic        in_resp_ready,
  output logic [31:0] in_resp_rdata,
  output logic        in_resp_err,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);
  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d, err_q, err_d;
  logic        accept, done, timeout;
`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .enable  (state_q == S_ACCESS && !out_pready),
    .clear   (state_q == S_SETUP),
    .expired (timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    accept  = state_q == S_IDLE && in_req_valid;
    done    = state_q == S_ACCESS && out_pready;
    state_d = accept ? S_SETUP :
              state_q == S_SETUP ? S_ACCESS :
              (done || timeout) ? S_RESP :
              (state_q == S_RESP && in_resp_ready) ? S_IDLE : state_q;
    addr_d  = accept ? in_req_addr : addr_q;
    write_d = accept ? in_req_write : write_q;
    // Reads latch zero write data so the APB bus never shows stale write payload.
    wdata_d = accept ? (in_req_write ? in_req_wdata : '0) : wdata_q;
    wstrb_d = accept ? (in_req_write ? in_req_wstrb : '0) : wstrb_q;
    rdata_d = done ? (write_q ? '0 : out_prdata) : timeout ? TIMEOUT_RDATA : rdata_q;
    err_d   = done ? out_pslverr : timeout | err_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  assign in_req_ready  = state_q == S_IDLE;
  assign in_resp_valid = state_q == S_RESP;
  assign in_resp_rdata = rdata_q;
  assign in_resp_err   = err_q;
  assign out_psel      = state_q == S_SETUP || state_q == S_ACCESS;
  assign out_penable   = state_q == S_ACCESS;
  assign out_pprot     = PPROT_VAL;
  assign out_paddr     = addr_q;
  assign out_pwrite    = write_q;
  assign out_pwdata    = wdata_q;
  assign out_pstrb     = wstrb_q;
endmodule

// File: tb/tb_cpu_apb_bridge.sv
// tb_cpu_apb_bridge: scoreboard bench for cpu_apb_bridge with a wait-state APB slave model.
// Define APB_TIMEOUT_EN to also exercise the timeout abort with TIMEOUT_CYCLES=8.
module tb_cpu_apb_bridge;
`ifdef APB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif
  localparam logic [2:0] PROT = 3'b010;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_req_valid = 1'b0, in_req_write = 1'b0, in_resp_ready = 1'b1;
  logic [31:0] in_req_addr = '0, in_req_wdata = '0;
  logic [3:0]  in_req_wstrb = '0;
  logic        in_req_ready, in_resp_valid, in_resp_err;
  logic [31:0] in_resp_rdata, out_paddr, out_pwdata, out_prdata;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;

  int          wait_n = 0;
  logic        stuck = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  int          acc_cnt;
  exp_t        sb[$];
  int          checks = 0, errors = 0;

  cpu_apb_bridge #(.TIMEOUT_CYCLES(TO), .PPROT_VAL(PROT)) dut (
    .clock(clock), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
    .in_req_addr(in_req_addr), .in_req_write(in_req_write),
    .in_req_wdata(in_req_wdata), .in_req_wstrb(in_req_wstrb),
    .in_resp_valid(in_resp_valid), .in_resp_ready(in_resp_ready),
    .in_resp_rdata(in_resp_rdata), .in_resp_err(in_resp_err),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset)
    if (!reset) acc_cnt <= 0;
    else acc_cnt <= (out_psel && out_penable && !out_pready) ? acc_cnt + 1 : 0;
  assign out_pready  = out_psel && out_penable && !stuck && acc_cnt >= wait_n;
  assign out_prdata  = slv_rdata;
  assign out_pslverr = slv_err;

  // Called at a negedge in IDLE; returns at the negedge of the SETUP cycle.
  task automatic start_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_e);
    in_req_valid = 1'b1; in_req_addr = a; in_req_write = w; in_req_wdata = d; in_req_wstrb = s;
    sb.push_back('{exp_rd, exp_e});
    @(negedge clock);
    in_req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output int n_acc);
    lat = 1; n_acc = 0;
    while (!in_resp_valid && lat < 400) begin
      @(negedge clock); lat++;
      if (out_psel && out_penable) n_acc++;
    end
    checks++;
    if (!in_resp_valid) begin
      errors++; $display("FAIL resp_wait: in_resp_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    checks++;
    if ({out_psel, out_penable, in_resp_valid, in_resp_err} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: psel/pen/rv/err=%b required 0000", {out_psel, out_penable, in_resp_valid, in_resp_err});
    end
    checks++;
    if ({out_paddr, out_pwrite, out_pwdata, out_pstrb, in_resp_rdata} !== '0) begin
      errors++; $display("FAIL reset_payload: addr=%h wdata=%h strb=%h rdata=%h required 0", out_paddr, out_pwdata, out_pstrb, in_resp_rdata);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (in_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: in_req_ready=%b required 1", in_req_ready);
    end
    checks++;
    if (out_pprot !== PROT) begin
      errors++; $display("FAIL pprot: %b required %b", out_pprot, PROT);
    end
  endtask

  task automatic test_read;
    int lat, n;
    exp_t e;
    wait_n = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
    start_req(32'h1000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 1'b0);
    checks++;
    if ({out_psel, out_penable, out_paddr, out_pwrite, out_pwdata, out_pstrb} !== {2'b10, 32'h1000_0004, 1'b0, 32'h0, 4'h0}) begin
      errors++; $display("FAIL read_setup: psel=%b pen=%b addr=%h wr=%b wdata=%h strb=%h required 1 0 10000004 0 0 0",
                         out_psel, out_penable, out_paddr, out_pwrite, out_pwdata, out_pstrb);
    end
    wait_resp(lat, n);
    e = sb.pop_front();
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency: %0d required 3", lat); end
    checks++;
    if ({in_resp_rdata, in_resp_err} !== {e.rdata, e.err}) begin
      errors++; $display("FAIL read_resp: rdata=%h err=%b required %h %b", in_resp_rdata, in_resp_err, e.rdata, e.err);
    end
    @(negedge clock);
    checks++;
    if ({in_resp_valid, in_req_ready} !== 2'b01) begin
      errors++; $display("FAIL read_idle: rv=%b rdy=%b required 0 1", in_resp_valid, in_req_ready);
    end
  endtask

  task automatic test_write_wait;
    int lat, n;
    exp_t e;
    wait_n = 4; slv_rdata = 32'h7777_7777;
    start_req(32'h1000_0008, 1'b1, 32'hA5A5_A5A5, 4'b0011, 32'h0, 1'b0);
    lat = 1; n = 0;
    while (!in_resp_valid && lat < 400) begin
      @(negedge clock); lat++;
      if (out_psel && out_penable) begin
        n++;
        checks++;
        if ({out_paddr, out_pwrite, out_pwdata, out_pstrb} !== {32'h1000_0008, 1'b1, 32'hA5A5_A5A5, 4'b0011}) begin
          errors++; $display("FAIL write_stable[%0d]: addr=%h wr=%b wdata=%h strb=%b", n, out_paddr, out_pwrite, out_pwdata, out_pstrb);
        end
      end
    end
    e = sb.pop_front();
    checks++;
    if (n !== 5 || lat !== 7) begin errors++; $display("FAIL write_access: %0d cycles lat %0d required 5 7", n, lat); end
    checks++;
    if ({in_resp_valid, in_resp_rdata, in_resp_err} !== {1'b1, e.rdata, e.err}) begin
      errors++; $display("FAIL write_resp: rv=%b rdata=%h err=%b required 1 %h %b", in_resp_valid, in_resp_rdata, in_resp_err, e.rdata, e.err);
    end
    @(negedge clock);
    wait_n = 0;
  endtask

  task automatic test_slverr_stall;
    int lat, n;
    exp_t e;
    slv_err = 1'b1; slv_rdata = 32'hCAFE_0001; in_resp_ready = 1'b0;
    start_req(32'h2000_0000, 1'b0, 32'h1111_1111, 4'hF, 32'hCAFE_0001, 1'b1);
    checks++;
    if ({in_req_ready, out_pwdata, out_pstrb} !== '0) begin
      errors++; $display("FAIL slverr_setup: rdy=%b wdata=%h strb=%h required 0 0 0", in_req_ready, out_pwdata, out_pstrb);
    end
    wait_resp(lat, n);
    slv_err = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_resp_valid, in_req_ready, in_resp_rdata, in_resp_err} !== {2'b10, e.rdata, e.err}) begin
        errors++; $display("FAIL slverr_hold[%0d]: rv=%b rdy=%b rdata=%h err=%b required 1 0 %h %b",
                           i, in_resp_valid, in_req_ready, in_resp_rdata, in_resp_err, e.rdata, e.err);
      end
      @(negedge clock);
    end
    in_resp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({in_resp_valid, in_req_ready} !== 2'b01) begin
      errors++; $display("FAIL slverr_release: rv=%b rdy=%b required 0 1", in_resp_valid, in_req_ready);
    end
  endtask

  task automatic test_back_to_back;
    int acc = 0, hs = 0;
    int acc_c[2], hs_c[2];
    exp_t e;
    in_req_valid = 1'b1; in_req_write = 1'b0; in_req_addr = 32'h3000_0000;
    for (int c = 0; c < 40 && hs < 2; c++) begin
      if (in_req_valid && in_req_ready) begin
        acc_c[acc] = c;
        slv_rdata = acc == 0 ? 32'h0BAD_F00D : 32'h600D_CAFE;
        sb.push_back('{slv_rdata, 1'b0});
        acc++;
      end
      if (in_resp_valid && in_resp_ready) begin
        e = sb.pop_front();
        checks++;
        if ({in_resp_rdata, in_resp_err} !== {e.rdata, e.err}) begin
          errors++; $display("FAIL b2b_resp[%0d]: rdata=%h err=%b required %h %b", hs, in_resp_rdata, in_resp_err, e.rdata, e.err);
        end
        hs_c[hs] = c;
        hs++;
      end
      @(negedge clock);
      in_req_valid = acc < 2;
      in_req_addr = 32'h3000_0010;
    end
    in_req_valid = 1'b0;
    checks++;
    if (acc !== 2 || hs !== 2) begin
      errors++; $display("FAIL b2b_count: accepts=%0d responses=%0d required 2 2", acc, hs);
    end else begin
      checks++;
      if (acc_c[1] !== hs_c[0] + 1) begin
        errors++; $display("FAIL b2b_gap: second accept cycle %0d required %0d", acc_c[1], hs_c[0] + 1);
      end
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    int lat, n;
    exp_t e;
    stuck = 1'b1;
    start_req(32'h4000_0000, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
    wait_resp(lat, n);
    e = sb.pop_front();
    checks++;
    if (n !== 8 || lat !== 10) begin errors++; $display("FAIL timeout_len: %0d access cycles lat %0d required 8 10", n, lat); end
    checks++;
    if ({out_psel, in_resp_rdata, in_resp_err} !== {1'b0, e.rdata, e.err}) begin
      errors++; $display("FAIL timeout_resp: psel=%b rdata=%h err=%b required 0 %h %b", out_psel, in_resp_rdata, in_resp_err, e.rdata, e.err);
    end
    stuck = 1'b0;
    @(negedge clock);
  endtask
`endif

  task automatic test_reset_mid_access;
    int lat, n;
    stuck = 1'b1;
    start_req(32'h5000_0000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    @(negedge clock);
    checks++;
    if ({out_psel, out_penable} !== 2'b11) begin
      errors++; $display("FAIL rst_mid_access: psel/pen=%b required 11", {out_psel, out_penable});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_psel, out_penable} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_async: psel/pen=%b required 00", {out_psel, out_penable});
    end
    sb.delete();
    stuck = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({in_resp_valid, in_req_ready} !== 2'b01) begin
        errors++; $display("FAIL rst_mid_after[%0d]: rv=%b rdy=%b required 0 1", i, in_resp_valid, in_req_ready);
      end
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_wait;
    test_slverr_stall;
    test_back_to_back;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_access;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
